// File: rtl/mctrl_gen_if.sv
// Control-unit <-> datapath bundle: IR/flags/ready in, Moore controls and status out.
interface mctrl_gen_if #(parameter int ALUOP_W = 3);
  logic [31:0]        Inst_in;
  logic               zero, overflow, MIO_ready;
  logic               MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA;
  logic               PCWrite, PCWriteCond, Branch, CPU_MIO, Trap, mem_timeout;
  logic [1:0]         RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [ALUOP_W-1:0] ALU_operation;
  logic [4:0]         state_out;

  modport master (
    input  Inst_in, zero, overflow, MIO_ready,
    output MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
           Branch, CPU_MIO, Trap, mem_timeout, RegDst, MemtoReg, ALUSrcB, PCSource,
           ALU_operation, state_out
  );
  modport slave (
    output Inst_in, zero, overflow, MIO_ready,
    input  MemRead, MemWrite, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite, PCWriteCond,
           Branch, CPU_MIO, Trap, mem_timeout, RegDst, MemtoReg, ALUSrcB, PCSource,
           ALU_operation, state_out
  );
endinterface

// File: rtl/mctrl_gen.sv
// Multi-cycle MIPS main controller: Moore decode with memory wait states,
// bounded wait timeout, overflow trap and sticky timeout status.
module mctrl_gen #(
  parameter int ALUOP_W      = 3,
  parameter int MEM_WAIT_MAX = 15,
  parameter int TRAP_EN      = 1,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset,
  mctrl_gen_if.master bus
);
  typedef enum logic [4:0] {
    S_IF = 5'd0, S_ID = 5'd1, S_EX_R = 5'd2, S_EX_MEM = 5'd3, S_EX_I = 5'd4,
    S_EX_BEQ = 5'd6, S_EX_BNE = 5'd7, S_EX_JR = 5'd8, S_EX_JAL = 5'd9, S_EX_J = 5'd10,
    S_MEM_RD = 5'd11, S_MEM_WD = 5'd12, S_WB_R = 5'd13, S_WB_I = 5'd14, S_WB_LW = 5'd15,
    S_TRAP = 5'd16, S_ERROR = 5'd31
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_XOR = 3'd3,
                         OP_NOR = 3'd4, OP_SRL = 3'd5, OP_SUB = 3'd6, OP_SLT = 3'd7;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic [5:0] opcode, funct;
  logic       rdy, is_wait, timeout, trap_r, trap_i;
  logic [2:0] r_op, i_op, alu3;
  logic       unused_in;

  assign opcode    = bus.Inst_in[31:26];
  assign funct     = bus.Inst_in[5:0];
  assign rdy       = bus.MIO_ready;
  assign unused_in = ^{bus.zero, bus.Inst_in[25:6]};

  always_comb begin
    case (funct)
      6'b100000: r_op = OP_ADD;
      6'b100010: r_op = OP_SUB;
      6'b100100: r_op = OP_AND;
      6'b100101: r_op = OP_OR;
      6'b100111: r_op = OP_NOR;
      6'b101010: r_op = OP_SLT;
      6'b000010: r_op = OP_SRL;
      6'b100110: r_op = OP_XOR;
      default:   r_op = OP_ADD;
    endcase
    case (opcode)
      6'b001100: i_op = OP_AND;
      6'b001101: i_op = OP_OR;
      6'b001110: i_op = OP_XOR;
      6'b001010: i_op = OP_SLT;
      default:   i_op = OP_ADD;   // addi, lui
    endcase
  end

  assign is_wait = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WD);
  // Ready in the limit cycle still wins, since the timeout needs !rdy.
  assign timeout = (MEM_WAIT_MAX > 0) && is_wait && !rdy &&
                   (cnt_q == CNT_W'(MEM_WAIT_MAX));
  assign trap_r  = (TRAP_EN != 0) && bus.overflow && (funct == 6'b100000 || funct == 6'b100010);
  assign trap_i  = (TRAP_EN != 0) && bus.overflow && (opcode == 6'b001000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IF;
      cnt_q         <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      S_IF:     if (rdy) state_d = S_ID;
      S_MEM_RD: if (rdy) state_d = S_WB_LW;
      S_MEM_WD: if (rdy) state_d = S_IF;
      S_ID: begin
        case (opcode)
          6'b000000: state_d = (funct == 6'b001000) ? S_EX_JR : S_EX_R;
          6'b100011, 6'b101011: state_d = S_EX_MEM;
          6'b000100: state_d = S_EX_BEQ;
          6'b000101: state_d = S_EX_BNE;
          6'b001000, 6'b001100, 6'b001101,
          6'b001110, 6'b001111, 6'b001010: state_d = S_EX_I;
          6'b000010: state_d = S_EX_J;
          6'b000011: state_d = S_EX_JAL;
          default:   state_d = S_ERROR;
        endcase
      end
      S_EX_MEM: state_d = (opcode == 6'b100011) ? S_MEM_RD : S_MEM_WD;
      S_EX_R:   state_d = trap_r ? S_TRAP : S_WB_R;
      S_EX_I:   state_d = trap_i ? S_TRAP : S_WB_I;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IF;
    endcase
    if (timeout) begin
      state_d       = S_ERROR;
      mem_timeout_d = 1'b1;
    end
    // Counter only survives while stalling in a wait state; any move clears it.
    cnt_d = '0;
    if (is_wait && !rdy && !timeout)
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  always_comb begin
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IorD        = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.Branch      = 1'b0;
    bus.CPU_MIO     = 1'b0;
    bus.Trap        = 1'b0;
    bus.RegDst      = 2'b00;
    bus.MemtoReg    = 2'b00;
    bus.ALUSrcB     = 2'b00;
    bus.PCSource    = 2'b00;
    alu3            = OP_AND;
    case (state_q)
      S_IF: begin
        bus.MemRead = 1'b1;
        bus.CPU_MIO = 1'b1;
        bus.ALUSrcB = 2'b01;
        alu3        = OP_ADD;
        bus.IRWrite = rdy;
        bus.PCWrite = rdy;
      end
      S_ID: begin
        bus.ALUSrcB = 2'b11;
        alu3        = OP_ADD;
      end
      S_EX_MEM: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        alu3        = OP_ADD;
      end
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        bus.CPU_MIO = 1'b1;
      end
      S_MEM_WD: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        bus.CPU_MIO  = 1'b1;
      end
      S_WB_LW: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'b01;
      end
      S_EX_R, S_WB_R: begin
        bus.ALUSrcA = 1'b1;
        alu3        = r_op;
        if (state_q == S_WB_R) begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'b01;
        end
      end
      S_EX_I, S_WB_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        alu3        = i_op;
        if (state_q == S_WB_I) begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = (opcode == 6'b001111) ? 2'b10 : 2'b00;
        end
      end
      S_EX_BEQ, S_EX_BNE: begin
        bus.ALUSrcA     = 1'b1;
        alu3            = OP_SUB;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.Branch      = (state_q == S_EX_BEQ);
      end
      S_EX_J: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      S_EX_JAL: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'b10;
        bus.MemtoReg = 2'b11;
      end
      S_EX_JR: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b11;
      end
      S_TRAP: begin
        bus.PCWrite = 1'b1;
        bus.Trap    = 1'b1;
      end
      default: ;
    endcase
    bus.ALU_operation = ALUOP_W'(alu3);
  end

  assign bus.state_out   = state_q;
  assign bus.mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_mctrl_gen.sv
// Bench for mctrl_gen: instruction table, hand-written wait/timeout/trap/reset
// sequences, and random instruction streams against a path-level model.
module tb_mctrl_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst = '0;
  logic        ovf = 1'b0, rdy = 1'b0;
  int          errs = 0, checks = 0;

  always #5 clk = ~clk;

  mctrl_gen_if #(.ALUOP_W(3)) b1();
  mctrl_gen_if #(.ALUOP_W(3)) b0();
  assign b1.Inst_in = inst;  assign b1.zero = 1'b0;  assign b1.overflow = ovf;  assign b1.MIO_ready = rdy;
  assign b0.Inst_in = inst;  assign b0.zero = 1'b0;  assign b0.overflow = ovf;  assign b0.MIO_ready = rdy;

  mctrl_gen #(.ALUOP_W(3), .MEM_WAIT_MAX(15), .TRAP_EN(1), .CNT_W(4)) dut  (.clk(clk), .reset(reset), .bus(b1.master));
  mctrl_gen #(.ALUOP_W(3), .MEM_WAIT_MAX(15), .TRAP_EN(0), .CNT_W(4)) dut0 (.clk(clk), .reset(reset), .bus(b0.master));

  typedef struct packed {
    logic mr, mw, iord, irw, rw, asa, pcw, pcwc, br, mio, trap;
    logic [1:0] rdst, m2r, asb, pcs;
    logic [2:0] alu;
  } ctl_t;

  ctl_t act;
  assign act = {b1.MemRead, b1.MemWrite, b1.IorD, b1.IRWrite, b1.RegWrite, b1.ALUSrcA,
                b1.PCWrite, b1.PCWriteCond, b1.Branch, b1.CPU_MIO, b1.Trap,
                b1.RegDst, b1.MemtoReg, b1.ALUSrcB, b1.PCSource, b1.ALU_operation};

  // ALU op by mnemonic: R-type by funct, I-type by opcode
  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'd2;  6'b100010: return 3'd6;
      6'b100100: return 3'd0;  6'b100101: return 3'd1;
      6'b100111: return 3'd4;  6'b101010: return 3'd7;
      6'b000010: return 3'd5;  6'b100110: return 3'd3;
      default:   return 3'd2;
    endcase
  endfunction
  function automatic logic [2:0] i_alu(input logic [5:0] o);
    case (o)
      6'b001100: return 3'd0;  6'b001101: return 3'd1;
      6'b001110: return 3'd3;  6'b001010: return 3'd7;
      default:   return 3'd2;
    endcase
  endfunction

  function automatic ctl_t exp_ctl(input logic [4:0] s, input logic [31:0] i, input logic r);
    ctl_t c;
    c = '0;
    case (s)
      5'd0:  begin c.mr = 1; c.mio = 1; c.asb = 2'd1; c.alu = 3'd2; c.irw = r; c.pcw = r; end
      5'd1:  begin c.asb = 2'd3; c.alu = 3'd2; end
      5'd3:  begin c.asa = 1; c.asb = 2'd2; c.alu = 3'd2; end
      5'd11: begin c.mr = 1; c.iord = 1; c.mio = 1; end
      5'd12: begin c.mw = 1; c.iord = 1; c.mio = 1; end
      5'd15: begin c.rw = 1; c.m2r = 2'd1; end
      5'd2:  begin c.asa = 1; c.alu = r_alu(i[5:0]); end
      5'd13: begin c.asa = 1; c.alu = r_alu(i[5:0]); c.rw = 1; c.rdst = 2'd1; end
      5'd4:  begin c.asa = 1; c.asb = 2'd2; c.alu = i_alu(i[31:26]); end
      5'd14: begin c.asa = 1; c.asb = 2'd2; c.alu = i_alu(i[31:26]); c.rw = 1;
                   c.m2r = (i[31:26] == 6'b001111) ? 2'd2 : 2'd0; end
      5'd6:  begin c.asa = 1; c.alu = 3'd6; c.pcwc = 1; c.pcs = 2'd1; c.br = 1; end
      5'd7:  begin c.asa = 1; c.alu = 3'd6; c.pcwc = 1; c.pcs = 2'd1; end
      5'd10: begin c.pcw = 1; c.pcs = 2'd2; end
      5'd9:  begin c.pcw = 1; c.pcs = 2'd2; c.rw = 1; c.rdst = 2'd2; c.m2r = 2'd3; end
      5'd8:  begin c.pcw = 1; c.pcs = 2'd3; end
      5'd16: begin c.pcw = 1; c.trap = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Inputs are already driven (posedge+1); check mid-cycle, then advance.
  task automatic step(input logic [4:0] s, input string nm);
    #1;
    chk({nm, " state"}, 32'(b1.state_out), 32'(s));
    chk({nm, " ctl"}, 32'(act), 32'(exp_ctl(s, inst, rdy)));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] f);
    return {6'b000000, 5'd3, 5'd4, 5'd5, 5'd0, f};
  endfunction
  function automatic logic [31:0] mk_i(input logic [5:0] o);
    return {o, 5'd1, 5'd2, 16'h1234};
  endfunction

  typedef struct {
    string       nm;
    logic [31:0] inst;
    logic        ov;
    logic [4:0]  p [4];   // states after ID, 0 = back in IF
    logic [2:0]  alu;     // ALU op in first post-ID state
    logic [1:0]  pcs;     // PCSource in first post-ID state
  } vec_t;
  vec_t tbl[$];

  function automatic void addv(input string nm, input logic [31:0] i, input logic ov,
                               input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                               input logic [2:0] alu, input logic [1:0] pcs);
    vec_t v;
    v.nm = nm; v.inst = i; v.ov = ov;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = 5'd0;
    v.alu = alu; v.pcs = pcs;
    tbl.push_back(v);
  endfunction

  // Random-stream model: expected (state, ready) per cycle for one instruction.
  typedef struct packed { logic [4:0] s; logic r; } ev_t;
  ev_t evq[$];

  function automatic void add_wait(input logic [4:0] s, input int k);
    ev_t e;
    for (int n = 0; n < k; n++) begin e.s = s; e.r = 1'b0; evq.push_back(e); end
    e.s = s; e.r = 1'b1; evq.push_back(e);
  endfunction
  function automatic void add_st(input logic [4:0] s);
    ev_t e;
    e.s = s; e.r = 1'($urandom_range(0, 1));
    evq.push_back(e);
  endfunction
  function automatic int stall();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
  endfunction

  function automatic void plan(input logic [31:0] i, input logic ov);
    logic [5:0] op, fn;
    op = i[31:26]; fn = i[5:0];
    add_wait(5'd0, stall());
    add_st(5'd1);
    case (op)
      6'b000000:
        if (fn == 6'b001000) add_st(5'd8);
        else begin
          add_st(5'd2);
          add_st((ov && (fn == 6'b100000 || fn == 6'b100010)) ? 5'd16 : 5'd13);
        end
      6'b100011: begin add_st(5'd3); add_wait(5'd11, stall()); add_st(5'd15); end
      6'b101011: begin add_st(5'd3); add_wait(5'd12, stall()); end
      6'b000100: add_st(5'd6);
      6'b000101: add_st(5'd7);
      6'b001000: begin add_st(5'd4); add_st(ov ? 5'd16 : 5'd14); end
      6'b000010: add_st(5'd10);
      6'b000011: add_st(5'd9);
      default:   begin add_st(5'd4); add_st(5'd14); end
    endcase
  endfunction

  initial begin
    #1000000;
    errs++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] rfn [10];
    logic [5:0] iop [12];
    logic [31:0] ri;
    ev_t e;

    addv("add",  mk_r(6'b100000), 0, 5'd2, 5'd13, 5'd0, 3'd2, 2'd0);
    addv("sub",  mk_r(6'b100010), 0, 5'd2, 5'd13, 5'd0, 3'd6, 2'd0);
    addv("and",  mk_r(6'b100100), 0, 5'd2, 5'd13, 5'd0, 3'd0, 2'd0);
    addv("or",   mk_r(6'b100101), 0, 5'd2, 5'd13, 5'd0, 3'd1, 2'd0);
    addv("nor",  mk_r(6'b100111), 0, 5'd2, 5'd13, 5'd0, 3'd4, 2'd0);
    addv("slt",  mk_r(6'b101010), 0, 5'd2, 5'd13, 5'd0, 3'd7, 2'd0);
    addv("srl",  mk_r(6'b000010), 0, 5'd2, 5'd13, 5'd0, 3'd5, 2'd0);
    addv("xor",  mk_r(6'b100110), 0, 5'd2, 5'd13, 5'd0, 3'd3, 2'd0);
    addv("sll",  mk_r(6'b000000), 0, 5'd2, 5'd13, 5'd0, 3'd2, 2'd0);
    addv("addv", mk_r(6'b100000), 1, 5'd2, 5'd16, 5'd0, 3'd2, 2'd0);
    addv("subv", mk_r(6'b100010), 1, 5'd2, 5'd16, 5'd0, 3'd6, 2'd0);
    addv("andv", mk_r(6'b100100), 1, 5'd2, 5'd13, 5'd0, 3'd0, 2'd0);
    addv("jr",   mk_r(6'b001000), 0, 5'd8, 5'd0, 5'd0, 3'd0, 2'd3);
    addv("lw",   mk_i(6'b100011), 0, 5'd3, 5'd11, 5'd15, 3'd2, 2'd0);
    addv("sw",   mk_i(6'b101011), 0, 5'd3, 5'd12, 5'd0, 3'd2, 2'd0);
    addv("beq",  mk_i(6'b000100), 0, 5'd6, 5'd0, 5'd0, 3'd6, 2'd1);
    addv("bne",  mk_i(6'b000101), 0, 5'd7, 5'd0, 5'd0, 3'd6, 2'd1);
    addv("addi", mk_i(6'b001000), 0, 5'd4, 5'd14, 5'd0, 3'd2, 2'd0);
    addv("addiv",mk_i(6'b001000), 1, 5'd4, 5'd16, 5'd0, 3'd2, 2'd0);
    addv("andi", mk_i(6'b001100), 0, 5'd4, 5'd14, 5'd0, 3'd0, 2'd0);
    addv("ori",  mk_i(6'b001101), 0, 5'd4, 5'd14, 5'd0, 3'd1, 2'd0);
    addv("xori", mk_i(6'b001110), 0, 5'd4, 5'd14, 5'd0, 3'd3, 2'd0);
    addv("oriv", mk_i(6'b001101), 1, 5'd4, 5'd14, 5'd0, 3'd1, 2'd0);
    addv("lui",  mk_i(6'b001111), 0, 5'd4, 5'd14, 5'd0, 3'd2, 2'd0);
    addv("slti", mk_i(6'b001010), 0, 5'd4, 5'd14, 5'd0, 3'd7, 2'd0);
    addv("j",    mk_i(6'b000010), 0, 5'd10, 5'd0, 5'd0, 3'd0, 2'd2);
    addv("jal",  mk_i(6'b000011), 0, 5'd9, 5'd0, 5'd0, 3'd0, 2'd2);

    // Reset state
    do_reset();
    rdy = 1'b0;
    #1;
    chk("reset state", 32'(b1.state_out), 32'd0);
    chk("reset mem_timeout", 32'(b1.mem_timeout), 32'd0);
    chk("reset IRWrite", 32'(b1.IRWrite), 32'd0);
    chk("reset MemWrite", 32'(b1.MemWrite), 32'd0);
    tick();

    // Table: full instruction paths with MIO_ready high
    do_reset();
    foreach (tbl[t]) begin
      inst = tbl[t].inst; ovf = tbl[t].ov; rdy = 1'b1;
      step(5'd0, {tbl[t].nm, " IF"});
      step(5'd1, {tbl[t].nm, " ID"});
      for (int k = 0; k < 4; k++) begin
        if (tbl[t].p[k] == 5'd0) break;
        if (k == 0) begin
          #1;
          chk({tbl[t].nm, " alu"}, 32'(b1.ALU_operation), 32'(tbl[t].alu));
          chk({tbl[t].nm, " pcsrc"}, 32'(b1.PCSource), 32'(tbl[t].pcs));
        end
        step(tbl[t].p[k], {tbl[t].nm, " path"});
      end
    end

    // lw with IF waits and three MEM_RD waits
    do_reset();
    inst = mk_i(6'b100011); ovf = 1'b0;
    rdy = 1'b0; step(5'd0, "lw ifwait"); step(5'd0, "lw ifwait");
    rdy = 1'b1; step(5'd0, "lw if"); step(5'd1, "lw id"); step(5'd3, "lw exmem");
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; chk("lw memrd MemRead", 32'(b1.MemRead), 32'd1);
      step(5'd11, "lw memrd wait");
    end
    rdy = 1'b1; step(5'd11, "lw memrd");
    #1; chk("lw wb MemtoReg", 32'(b1.MemtoReg), 32'd1);
    step(5'd15, "lw wb");
    step(5'd0, "lw back");

    // Ready arriving exactly at the timeout limit still proceeds
    do_reset();
    inst = mk_r(6'b100000); rdy = 1'b0;
    for (int k = 0; k < 15; k++) step(5'd0, "edge wait");
    rdy = 1'b1; step(5'd0, "edge if");
    #1; chk("edge mem_timeout", 32'(b1.mem_timeout), 32'd0);
    step(5'd1, "edge id");

    // Stuck IF -> ERROR after 16 cycles, sticky until reset
    do_reset();
    rdy = 1'b0;
    for (int k = 0; k < 16; k++) step(5'd0, "to if wait");
    for (int k = 0; k < 20; k++) begin
      rdy = 1'($urandom_range(0, 1));
      #1; chk("to mem_timeout", 32'(b1.mem_timeout), 32'd1);
      step(5'd31, "to error");
    end
    do_reset();
    #1;
    chk("to reset state", 32'(b1.state_out), 32'd0);
    chk("to reset mem_timeout", 32'(b1.mem_timeout), 32'd0);
    tick();

    // Stuck MEM_WD -> ERROR
    do_reset();
    inst = mk_i(6'b101011); rdy = 1'b1;
    step(5'd0, "swto if"); step(5'd1, "swto id"); step(5'd3, "swto exmem");
    rdy = 1'b0;
    for (int k = 0; k < 16; k++) step(5'd12, "swto wait");
    #1; chk("swto mem_timeout", 32'(b1.mem_timeout), 32'd1);
    step(5'd31, "swto error");

    // Trap vs. no-trap build on addi overflow
    do_reset();
    inst = mk_i(6'b001000); ovf = 1'b1; rdy = 1'b1;
    step(5'd0, "trap if"); step(5'd1, "trap id");
    #1; chk("notrap exi", 32'(b0.state_out), 32'd4);
    step(5'd4, "trap exi");
    #1;
    chk("trap Trap", 32'(b1.Trap), 32'd1);
    chk("trap RegWrite", 32'(b1.RegWrite), 32'd0);
    chk("notrap state", 32'(b0.state_out), 32'd14);
    chk("notrap RegWrite", 32'(b0.RegWrite), 32'd1);
    step(5'd16, "trap");
    step(5'd0, "trap back");
    ovf = 1'b0;

    // Illegal opcode holds ERROR, no timeout flag
    do_reset();
    inst = {6'b111111, 26'h0}; rdy = 1'b1;
    step(5'd0, "ill if"); step(5'd1, "ill id");
    for (int k = 0; k < 20; k++) begin
      rdy = 1'($urandom_range(0, 1));
      #1; chk("ill mem_timeout", 32'(b1.mem_timeout), 32'd0);
      step(5'd31, "ill error");
    end

    // Reset during MEM_WD abandons the store
    do_reset();
    inst = mk_i(6'b101011); rdy = 1'b1;
    step(5'd0, "rst if"); step(5'd1, "rst id"); step(5'd3, "rst exmem");
    rdy = 1'b0;
    step(5'd12, "rst memwd"); step(5'd12, "rst memwd");
    do_reset();
    #1; chk("rst MemWrite", 32'(b1.MemWrite), 32'd0);
    step(5'd0, "rst after");

    // Random instruction stream against the path model
    rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
            6'b101010, 6'b000010, 6'b100110, 6'b000000, 6'b001000};
    iop = '{6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b001100,
            6'b001101, 6'b001110, 6'b001111, 6'b001010, 6'b000010, 6'b000011};
    do_reset();
    for (int n = 0; n < 150; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 1) == 0) ri = {6'b000000, ri[25:6], rfn[$urandom_range(0, 9)]};
      else                           ri = {iop[$urandom_range(0, 11)], ri[25:0]};
      inst = ri;
      ovf  = 1'($urandom_range(0, 1));
      evq.delete();
      plan(ri, ovf);
      while (evq.size() > 0) begin
        e = evq.pop_front();
        rdy = e.r;
        step(e.s, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
